// File: rtl/sys1_scan_driver.sv
// System1 front-panel scan driver: multiplexed 8-digit display, keypad debounce and key FIFO.
// Optional key auto-repeat is compiled in when SYS1_SCAN_AUTOREPEAT_EN is defined.
module sys1_scan_driver #(
  parameter int DWELL      = 3125,
  parameter int BLANK      = 25,
  parameter int DEBOUNCE   = 4,
  parameter int FIFO_DEPTH = 4
`ifdef SYS1_SCAN_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100
`endif
) (
  input  logic       clk25,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic [7:0] seg_out,
  output logic [2:0] dig_sel,
  input  logic [2:0] ret_n,
  output logic [4:0] key_code,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       overflow,
  input  logic       ovf_clr
);
  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam int AW = $clog2(FIFO_DEPTH);

  // ---------------- scan timing ----------------
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    dig_nxt;
  logic          dwell_end, frame_end;
  logic [7:0]    disp_buf [8];

  assign dwell_end = (cnt == CW'(DWELL - 1));
  assign frame_end = dwell_end && (dig_sel == 3'd0);

  always_comb begin
    cnt_nxt = dwell_end ? '0 : cnt + CW'(1);
    dig_nxt = dwell_end ? dig_sel - 3'd1 : dig_sel;
  end

  // seg_out is computed from the next count/digit so it lines up with dig_sel
  always_ff @(posedge clk25 or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      dig_sel <= 3'd7;
      seg_out <= 8'h00;
    end else begin
      cnt     <= cnt_nxt;
      dig_sel <= dig_nxt;
      seg_out <= (cnt_nxt < CW'(BLANK)) ? 8'h00 : disp_buf[dig_nxt];
    end
  end

  always_ff @(posedge clk25 or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) disp_buf[i] <= 8'h00;
    end else if (wr_en) begin
      disp_buf[wr_addr] <= wr_data;
    end
  end

  // ---------------- return-line sampling ----------------
  logic [2:0] ret_s1, ret_s2;
  logic       hit, fk_have, fk_now_have;
  logic [1:0] hit_row;
  logic [4:0] fk, fk_now;

  always_comb begin
    hit     = ~&ret_s2;
    hit_row = 2'd2;
    if (!ret_s2[2])      hit_row = 2'd0;
    else if (!ret_s2[1]) hit_row = 2'd1;
    fk_now_have = fk_have;
    fk_now      = fk;
    // only the first low line of the frame is kept
    if (dwell_end && !fk_have && hit) begin
      fk_now_have = 1'b1;
      fk_now      = {dig_sel, hit_row};
    end
  end

  always_ff @(posedge clk25 or posedge reset) begin
    if (reset) begin
      ret_s1  <= 3'b111;
      ret_s2  <= 3'b111;
      fk_have <= 1'b0;
      fk      <= '0;
    end else begin
      ret_s1 <= ret_n;
      ret_s2 <= ret_s1;
      if (frame_end) begin
        fk_have <= 1'b0;
        fk      <= '0;
      end else begin
        fk_have <= fk_now_have;
        fk      <= fk_now;
      end
    end
  end

  // ---------------- debounce FSM ----------------
  typedef enum logic [1:0] {S_IDLE, S_PRESS, S_HELD, S_REL} state_t;
  state_t        state, state_nxt;
  logic [DW-1:0] dcnt, dcnt_nxt;
  logic [4:0]    cand, cand_nxt, push_code;
  logic          push_req, push_nxt;
  logic          same;

`ifdef SYS1_SCAN_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);
  logic [RW-1:0] rpt, rpt_nxt, rpt_lim;
  logic          rpt_on, rpt_on_nxt;
  assign rpt_lim = rpt_on ? RW'(REPEAT_RATE - 1) : RW'(REPEAT_DELAY - 1);
`endif

  assign same = fk_now_have && (fk_now == cand);

  always_comb begin
    state_nxt = state;
    dcnt_nxt  = dcnt;
    cand_nxt  = cand;
    push_nxt  = 1'b0;
`ifdef SYS1_SCAN_AUTOREPEAT_EN
    rpt_nxt    = rpt;
    rpt_on_nxt = rpt_on;
`endif
    if (frame_end) begin
      unique case (state)
        S_IDLE: begin
          if (fk_now_have) begin
            cand_nxt = fk_now;
            dcnt_nxt = DW'(1);
            if (DEBOUNCE <= 1) begin
              push_nxt  = 1'b1;
              state_nxt = S_HELD;
            end else begin
              state_nxt = S_PRESS;
            end
          end
        end
        S_PRESS: begin
          if (!fk_now_have) begin
            state_nxt = S_IDLE;
          end else if (same) begin
            if (dcnt == DW'(DEBOUNCE - 1)) begin
              push_nxt  = 1'b1;
              state_nxt = S_HELD;
            end else begin
              dcnt_nxt = dcnt + DW'(1);
            end
          end else begin
            cand_nxt = fk_now;
            dcnt_nxt = DW'(1);
          end
        end
        S_HELD: begin
          if (!same) begin
            state_nxt = (DEBOUNCE <= 1) ? S_IDLE : S_REL;
            dcnt_nxt  = DW'(1);
`ifdef SYS1_SCAN_AUTOREPEAT_EN
            rpt_nxt    = '0;
            rpt_on_nxt = 1'b0;
          end else if (rpt == rpt_lim) begin
            push_nxt   = 1'b1;
            rpt_nxt    = '0;
            rpt_on_nxt = 1'b1;
          end else begin
            rpt_nxt = rpt + RW'(1);
`endif
          end
        end
        S_REL: begin
          if (same) begin
            state_nxt = S_HELD;
          end else if (dcnt == DW'(DEBOUNCE - 1)) begin
            state_nxt = S_IDLE;
          end else begin
            dcnt_nxt = dcnt + DW'(1);
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk25 or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      dcnt      <= '0;
      cand      <= '0;
      push_req  <= 1'b0;
      push_code <= '0;
`ifdef SYS1_SCAN_AUTOREPEAT_EN
      rpt       <= '0;
      rpt_on    <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      dcnt      <= dcnt_nxt;
      cand      <= cand_nxt;
      push_req  <= push_nxt;
      push_code <= cand_nxt;
`ifdef SYS1_SCAN_AUTOREPEAT_EN
      rpt       <= rpt_nxt;
      rpt_on    <= rpt_on_nxt;
`endif
    end
  end

  // ---------------- key FIFO ----------------
  logic [AW:0] wp, rp;
  logic [4:0]  mem [FIFO_DEPTH];
  logic        full, pop, do_push, drop;

  assign key_valid = (wp != rp);
  assign full      = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign pop       = key_ack && key_valid;
  // a pop on the same edge frees the slot the push needs
  assign do_push   = push_req && (!full || pop);
  assign drop      = push_req && full && !pop;
  assign key_code  = key_valid ? mem[rp[AW-1:0]] : 5'd0;

  always_ff @(posedge clk25 or posedge reset) begin
    if (reset) begin
      wp       <= '0;
      rp       <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (pop) rp <= rp + (AW+1)'(1);
      if (do_push) begin
        mem[wp[AW-1:0]] <= push_code;
        wp              <= wp + (AW+1)'(1);
      end
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sys1_scan_driver.sv
// Bench for sys1_scan_driver: keypad emulation driven from a frame-level reference model.
module tb_sys1_scan_driver;
  localparam int DWELL = 16, BLANK = 2, DEB = 4, DEPTH = 4, FRAME = 8 * DWELL;
`ifdef SYS1_SCAN_AUTOREPEAT_EN
  localparam int RDELAY = 10, RRATE = 3;
`endif

  logic       clk25 = 1'b0, reset = 1'b1, wr_en = 1'b0, key_ack = 1'b0, ovf_clr = 1'b0;
  logic [2:0] wr_addr = 3'd0, ret_n = 3'b111, dig_sel;
  logic [7:0] wr_data = 8'h00, seg_out;
  logic [4:0] key_code;
  logic       key_valid, overflow;

  sys1_scan_driver #(.DWELL(DWELL), .BLANK(BLANK), .DEBOUNCE(DEB), .FIFO_DEPTH(DEPTH)
`ifdef SYS1_SCAN_AUTOREPEAT_EN
    , .REPEAT_DELAY(RDELAY), .REPEAT_RATE(RRATE)
`endif
  ) dut (
    .clk25(clk25), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .seg_out(seg_out), .dig_sel(dig_sel), .ret_n(ret_n), .key_code(key_code),
    .key_valid(key_valid), .key_ack(key_ack), .overflow(overflow), .ovf_clr(ovf_clr)
  );

  always #5 clk25 = ~clk25;

  int checks = 0, failures = 0;

  // reference model state
  int          edges;
  logic [7:0]  mbuf [8];
  logic [23:0] pm = '0;          // pressed keys, bit digit*3+row
  int          q[$];
  bit          movf;
  int          push_edge, push_val;
  bit          holding;
  int          streak, cand, rep;
  bit          rep_on;
  logic [2:0]  exp_dig;
  logic [7:0]  exp_seg;
  bit          exp_v;
  logic [4:0]  exp_c;

  function automatic logic [23:0] kbit(int c);
    logic [23:0] m;
    m = '0;
    m[(c / 4) * 3 + c % 4] = 1'b1;
    return m;
  endfunction

  function automatic int rkey();
    int d, r;
    d = int'($urandom_range(7, 0));
    r = int'($urandom_range(2, 0));
    return d * 4 + r;
  endfunction

  function automatic int frame_key();
    for (int d = 7; d >= 0; d--)
      for (int r = 0; r < 3; r++)
        if (pm[d * 3 + r]) return d * 4 + r;
    return -1;
  endfunction

  task automatic model_reset();
    edges = 0;
    for (int i = 0; i < 8; i++) mbuf[i] = 8'h00;
    q.delete();
    movf = 0; push_edge = -1; push_val = 0;
    holding = 0; streak = 0; cand = -1; rep = 0; rep_on = 0;
    exp_dig = 3'd7; exp_seg = 8'h00; exp_v = 0; exp_c = 5'd0;
  endtask

  task automatic drive_ret();
    for (int r = 0; r < 3; r++) ret_n[2 - r] = ~pm[int'(exp_dig) * 3 + r];
  endtask

  task automatic schedule_push();
    push_edge = edges + 1;
    push_val  = cand;
  endtask

  // one debounce decision per completed frame
  task automatic frame_end_model();
    int fk;
    fk = frame_key();
    if (!holding) begin
      if (streak == 0) begin
        if (fk >= 0) begin cand = fk; streak = 1; end
      end else if (fk < 0) begin
        streak = 0;
      end else if (fk != cand) begin
        cand = fk; streak = 1;
      end else begin
        streak++;
        if (streak == DEB) begin
          holding = 1; streak = 0; rep = 0; rep_on = 0;
          schedule_push();
        end
      end
    end else if (streak == 0) begin
      if (fk != cand) streak = 1;
`ifdef SYS1_SCAN_AUTOREPEAT_EN
      else begin
        rep++;
        if (rep == (rep_on ? RRATE : RDELAY)) begin
          schedule_push(); rep = 0; rep_on = 1;
        end
      end
`endif
    end else begin
      if (fk == cand) begin
        streak = 0; rep = 0; rep_on = 0;
      end else begin
        streak++;
        if (streak == DEB) begin holding = 0; streak = 0; end
      end
    end
  endtask

  task automatic step();
    bit pop_ok, we, oc, drop;
    int sz0;
    logic [2:0] wa;
    logic [7:0] wd;
    pop_ok = key_ack && (q.size() > 0);
    sz0 = q.size(); we = wr_en; wa = wr_addr; wd = wr_data; oc = ovf_clr; drop = 0;
    @(posedge clk25); #1;
    edges++;
    if (pop_ok) void'(q.pop_front());
    if (push_edge == edges) begin
      if (sz0 == DEPTH && !pop_ok) drop = 1;
      else q.push_back(push_val);
    end
    movf = drop ? 1'b1 : (oc ? 1'b0 : movf);
    if (edges % FRAME == 0) frame_end_model();
    exp_dig = 3'(7 - (edges / DWELL) % 8);
    exp_seg = (edges % DWELL < BLANK) ? 8'h00 : mbuf[exp_dig];
    if (we) mbuf[wa] = wd;
    exp_v = q.size() > 0;
    exp_c = exp_v ? 5'(q[0]) : 5'd0;
    drive_ret();
  endtask

  task automatic sync_frame();
    while (edges % FRAME != 0) step();
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * DEPTH && q.size() > 0; i++) begin
      key_ack = 1'b1; step(); key_ack = 1'b0;
    end
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
  endtask

  task automatic test_reset();
    model_reset();
    repeat (3) @(posedge clk25);
    #1;
    checks += 5;
    if (seg_out !== 8'h00) begin failures++; $display("FAIL reset_seg got=%h exp=00", seg_out); end
    if (dig_sel !== 3'd7) begin failures++; $display("FAIL reset_dig got=%0d exp=7", dig_sel); end
    if (key_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", key_valid); end
    if (key_code !== 5'd0) begin failures++; $display("FAIL reset_code got=%h exp=0", key_code); end
    if (overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
    reset = 1'b0;
    drive_ret();
  endtask

  task automatic test_scan();
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'h4F;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      checks++;
      if (dig_sel !== exp_dig || seg_out !== exp_seg) begin
        failures++;
        $display("FAIL scan edge=%0d got dig=%0d seg=%h exp dig=%0d seg=%h", edges, dig_sel, seg_out, exp_dig, exp_seg);
      end
      wr_en = 1'b0;
      // second frame: rewrite the lit digit mid-dwell plus random writes elsewhere
      if (i >= FRAME && edges % DWELL == 6) begin
        wr_en = 1'b1; wr_addr = exp_dig; wr_data = 8'($urandom);
      end else if (i >= FRAME && i % 7 == 0) begin
        wr_en = 1'b1; wr_addr = 3'($urandom_range(7, 0)); wr_data = 8'($urandom);
      end
    end
    wr_en = 1'b0;
  endtask

  task automatic test_single_press();
    sync_frame();
    pm = kbit(5 * 4 + 1);
    drive_ret();
    for (int f = 0; f < 11; f++) begin
      if (f == 6) pm = '0;
      for (int i = 0; i < FRAME; i++) begin
        step();
        checks++;
        if (key_valid !== exp_v || overflow !== movf || (exp_v && key_code !== exp_c)) begin
          failures++;
          $display("FAIL single edge=%0d got v=%b c=%h o=%b exp v=%b c=%h o=%b", edges, key_valid, key_code, overflow, exp_v, exp_c, movf);
        end
      end
      if (f == 4) begin
        checks++;
        if (key_valid !== 1'b1 || key_code !== 5'b101_01) begin
          failures++; $display("FAIL single_code got v=%b c=%b exp v=1 c=10101", key_valid, key_code);
        end
      end
    end
    drain();
  endtask

  task automatic test_two_keys();
    logic [23:0] plan[$];
    int a, b;
    a = rkey(); b = (a + 4) % 32;
    repeat (6) plan.push_back(kbit(6 * 4 + 2) | kbit(2 * 4 + 0));
    repeat (5) plan.push_back('0);
    for (int k = 0; k < 8; k++) plan.push_back(kbit((k % 2) ? b : a));
    repeat (5) plan.push_back('0);
    sync_frame();
    foreach (plan[f]) begin
      pm = plan[f];
      for (int i = 0; i < FRAME; i++) begin
        step();
        checks++;
        if (key_valid !== exp_v || overflow !== movf || (exp_v && key_code !== exp_c)) begin
          failures++;
          $display("FAIL two_keys edge=%0d got v=%b c=%h o=%b exp v=%b c=%h o=%b", edges, key_valid, key_code, overflow, exp_v, exp_c, movf);
        end
      end
      if (f == 5) begin
        checks++;
        if (key_code !== 5'b110_10) begin failures++; $display("FAIL two_keys_code got=%b exp=11010", key_code); end
      end
    end
    drain();
  endtask

  task automatic test_fifo_overflow();
    logic [23:0] plan[$];
    int c;
    sync_frame();
    for (int k = 0; k < 5; k++) begin
      c = rkey();
      repeat (4) plan.push_back(kbit(c));
      repeat (5) plan.push_back('0);
    end
    foreach (plan[f]) begin
      pm = plan[f];
      for (int i = 0; i < FRAME; i++) begin
        step();
        checks++;
        if (key_valid !== exp_v || overflow !== movf || (exp_v && key_code !== exp_c)) begin
          failures++;
          $display("FAIL ovf_fill edge=%0d got v=%b c=%h o=%b exp v=%b c=%h o=%b", edges, key_valid, key_code, overflow, exp_v, exp_c, movf);
        end
      end
    end
    checks++;
    if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b exp=1", overflow); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (key_valid !== 1'b1 || key_code !== exp_c) begin
        failures++; $display("FAIL ovf_pop%0d got v=%b c=%h exp v=1 c=%h", k, key_valid, key_code, exp_c);
      end
      key_ack = 1'b1; step(); key_ack = 1'b0;
    end
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
    checks++;
    if (key_valid !== 1'b0 || overflow !== 1'b0) begin
      failures++; $display("FAIL ovf_clear got v=%b o=%b exp v=0 o=0", key_valid, overflow);
    end
    // refill to full, then a push with a same-edge ack, then a push with a same-edge ovf_clr
    plan.delete();
    for (int k = 0; k < 6; k++) begin
      c = rkey();
      repeat (4) plan.push_back(kbit(c));
      repeat (5) plan.push_back('0);
    end
    foreach (plan[f]) begin
      pm = plan[f];
      for (int i = 0; i < FRAME; i++) begin
        key_ack = (f / 9 == 4) && (push_edge == edges + 1);
        ovf_clr = (f / 9 == 5) && (push_edge == edges + 1);
        step();
        checks++;
        if (key_valid !== exp_v || overflow !== movf || (exp_v && key_code !== exp_c)) begin
          failures++;
          $display("FAIL ovf_edge edge=%0d got v=%b c=%h o=%b exp v=%b c=%h o=%b", edges, key_valid, key_code, overflow, exp_v, exp_c, movf);
        end
      end
      if (f == 44) begin
        checks++;
        if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_push_pop got=%b exp=0", overflow); end
      end
    end
    key_ack = 1'b0; ovf_clr = 1'b0;
    checks++;
    if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set_wins got=%b exp=1", overflow); end
    drain();
  endtask

  task automatic test_autorepeat();
    int c;
    c = rkey();
    sync_frame();
    for (int f = 0; f < 24; f++) begin
      pm = (f < 19) ? kbit(c) : '0;
      for (int i = 0; i < FRAME; i++) begin
        step();
        checks++;
        if (key_valid !== exp_v || overflow !== movf || (exp_v && key_code !== exp_c)) begin
          failures++;
          $display("FAIL repeat edge=%0d got v=%b c=%h o=%b exp v=%b c=%h o=%b", edges, key_valid, key_code, overflow, exp_v, exp_c, movf);
        end
      end
    end
    drain();
  endtask

  task automatic test_reset_mid();
    sync_frame();
    pm = kbit(rkey());
    repeat (5 * FRAME) step();
    while (edges % DWELL != 7) step();
    checks++;
    if (key_valid !== 1'b1) begin failures++; $display("FAIL mid_pre_valid got=%b exp=1", key_valid); end
    #3 reset = 1'b1;
    #1;
    checks++;
    if (seg_out !== 8'h00 || dig_sel !== 3'd7 || key_valid !== 1'b0 || key_code !== 5'd0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL mid_async got seg=%h dig=%0d v=%b c=%h o=%b exp 00/7/0/0/0", seg_out, dig_sel, key_valid, key_code, overflow);
    end
    repeat (2) @(posedge clk25);
    #1;
    reset = 1'b0;
    model_reset();
    drive_ret();
    for (int i = 0; i < 6 * FRAME; i++) begin
      step();
      checks++;
      if (dig_sel !== exp_dig || seg_out !== exp_seg || key_valid !== exp_v || (exp_v && key_code !== exp_c) || overflow !== movf) begin
        failures++;
        $display("FAIL mid_after edge=%0d got dig=%0d seg=%h v=%b c=%h o=%b exp dig=%0d seg=%h v=%b c=%h o=%b",
                 edges, dig_sel, seg_out, key_valid, key_code, overflow, exp_dig, exp_seg, exp_v, exp_c, movf);
      end
    end
    pm = '0;
    repeat (5 * FRAME) step();
    drain();
  endtask

  initial begin
    test_reset();
    test_scan();
    test_single_press();
    test_two_keys();
    test_fifo_overflow();
    test_autorepeat();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
